// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory-macro signals around mem_arbiter.
// The arbiter takes the slave view; requesters and the memory sit on the master side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    output if_done, if_rdata, d_done, d_rdata, d_err,
           mem_en, mem_wr, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    input  if_done, if_rdata, d_done, d_rdata, d_err,
           mem_en, mem_wr, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch and
// the data path; alternates under contention and answers with a one-cycle done pulse.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {FETCH = 1'b0, DATA = 1'b1} req_t;

  state_t            state, state_next;
  req_t              grant, last_grant;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] resp_q;
  logic              wr_q;
  logic              err_q;
  logic              any_req;
  logic              pick_data;

  // Alternate only when both ask; a lone requester always wins.
  always_comb begin
    any_req   = bus.if_req | bus.d_req;
    pick_data = bus.d_req && (!bus.if_req || last_grant == FETCH);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned
    // and no latch is inferred.
    state_next = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          if (pick_data && bus.d_addr[0]) state_next = RESP;
          else                            state_next = ACCESS;
        end
      end
      ACCESS:  if (cnt == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= FETCH;
      last_grant <= FETCH;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      resp_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            cnt    <= CNT_W'(MEM_LAT - 1);
            resp_q <= '0;
            if (pick_data) begin
              grant      <= DATA;
              last_grant <= DATA;
              addr_q     <= bus.d_addr;
              wdata_q    <= bus.d_wdata;
              wr_q       <= bus.d_wr;
              err_q      <= bus.d_addr[0];
            end else begin
              grant      <= FETCH;
              last_grant <= FETCH;
              addr_q     <= bus.if_addr;
              wdata_q    <= '0;
              wr_q       <= 1'b0;
              err_q      <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) resp_q <= wr_q ? '0 : bus.mem_rdata;
          else           cnt    <= cnt - 1'b1;
        end
        RESP:    err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Outputs decode straight from registered state, so reset clears them at once.
  always_comb begin
    bus.mem_en    = (state == ACCESS);
    bus.mem_wr    = bus.mem_en && wr_q;
    bus.mem_addr  = bus.mem_en ? addr_q  : '0;
    bus.mem_wdata = bus.mem_en ? wdata_q : '0;
    bus.if_done   = (state == RESP) && (grant == FETCH);
    bus.d_done    = (state == RESP) && (grant == DATA);
    bus.if_rdata  = bus.if_done ? resp_q : '0;
    bus.d_rdata   = bus.d_done  ? resp_q : '0;
    bus.d_err     = bus.d_done && err_q;
    bus.busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level reference model,
// followed by directed misaligned, reset-mid-access and dropped-request cases.
module tb_mem_arbiter;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int MEM_LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Memory macro seen by the DUT: 256 words indexed by the low address byte.
  logic [15:0] dut_mem [256];
  logic        poke = 1'b0;
  logic [7:0]  poke_addr = '0;
  logic [15:0] poke_data = '0;

  function automatic logic [15:0] init_word(int i);
    return 16'(i * 40503) ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) dut_mem[i] <= init_word(i);
    end else if (poke) begin
      dut_mem[poke_addr] <= poke_data;
    end else if (bus.mem_en && bus.mem_wr) begin
      dut_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = dut_mem[bus.mem_addr[7:0]];

  // Reference model: one outstanding transaction with its predicted window.
  typedef struct {
    bit          valid;
    bit          is_data;
    bit          mis;
    bit          wr;
    int          grant;
    int          done;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } txn_t;

  txn_t        t;
  logic [15:0] ref_mem [256];
  int          cyc;
  int          next_free;
  bit          last_data;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    t.valid   = 1'b0;
    next_free = 0;
    last_data = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
  endtask

  // Called just after each rising edge with the inputs the DUT sampled.
  task automatic model_step();
    bit take_data;
    if (cyc >= next_free && (bus.if_req || bus.d_req)) begin
      take_data = bus.d_req && (!bus.if_req || !last_data);
      last_data = take_data;
      t.valid   = 1'b1;
      t.is_data = take_data;
      t.grant   = cyc;
      if (take_data) begin
        t.addr  = bus.d_addr;
        t.wr    = bus.d_wr;
        t.wdata = bus.d_wdata;
        t.mis   = bus.d_addr[0];
      end else begin
        t.addr  = bus.if_addr;
        t.wr    = 1'b0;
        t.wdata = '0;
        t.mis   = 1'b0;
      end
      t.done    = cyc + (t.mis ? 0 : MEM_LAT);
      t.rdata   = (t.mis || t.wr) ? 16'h0 : ref_mem[t.addr[7:0]];
      if (t.wr && !t.mis) ref_mem[t.addr[7:0]] = t.wdata;
      next_free = t.done + 2;
    end
  endtask

  task automatic check_outputs();
    bit active, en, dn;
    active = t.valid && cyc >= t.grant && cyc <= t.done;
    en     = active && !t.mis && cyc < t.done;
    dn     = t.valid && cyc == t.done;
    check("busy",     32'(bus.busy),    32'(active));
    check("mem_en",   32'(bus.mem_en),  32'(en));
    check("mem_wr",   32'(bus.mem_wr),  32'(en && t.wr));
    check("if_done",  32'(bus.if_done), 32'(dn && !t.is_data));
    check("d_done",   32'(bus.d_done),  32'(dn && t.is_data));
    check("if_rdata", 32'(bus.if_rdata), (dn && !t.is_data) ? 32'(t.rdata) : 32'h0);
    check("d_rdata",  32'(bus.d_rdata),  (dn && t.is_data)  ? 32'(t.rdata) : 32'h0);
    check("d_err",    32'(bus.d_err),   32'(dn && t.is_data && t.mis));
    if (en) begin
      check("mem_addr", 32'(bus.mem_addr), 32'(t.addr));
      if (t.wr) check("mem_wdata", 32'(bus.mem_wdata), 32'(t.wdata));
    end
  endtask

  // Requesters: drop req in the done cycle; optionally raise new requests and
  // wiggle the buses (changes after a grant must be ignored).
  task automatic drive(input bit allow_new);
    logic [31:0] r;
    if (bus.if_done) begin
      bus.if_req = 1'b0;
    end else if (allow_new) begin
      r = $urandom;
      if (!bus.if_req && $urandom_range(0, 2) == 0) bus.if_req = 1'b1;
      if ($urandom_range(0, 3) == 0) bus.if_addr = r[15:0];
    end
    if (bus.d_done) begin
      bus.d_req = 1'b0;
    end else if (allow_new) begin
      r = $urandom;
      if (!bus.d_req && $urandom_range(0, 2) == 0) bus.d_req = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        bus.d_addr  = {r[15:1], ($urandom_range(0, 3) == 0)};
        bus.d_wr    = r[16];
        bus.d_wdata = r[31:16];
      end
    end
  endtask

  task automatic run_cycles(input int n, input bit allow_new);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      model_step();
      @(negedge clk);
      check_outputs();
      drive(allow_new);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (bus.if_req || bus.d_req || cyc < next_free); i++)
      run_cycles(1, 1'b0);
    check("drain", 32'(bus.if_req || bus.d_req || bus.busy), 32'h0);
  endtask

  initial begin
    cyc = 0;
    model_reset();
    // Both requesters held from reset: first contended grant must go to DATA.
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0010;
    bus.d_req   = 1'b1;
    bus.d_wr    = 1'b1;
    bus.d_addr  = 16'h0100;
    bus.d_wdata = 16'h1234;

    repeat (2) @(negedge clk);
    check("rst_busy",    32'(bus.busy),    32'h0);
    check("rst_mem_en",  32'(bus.mem_en),  32'h0);
    check("rst_if_done", 32'(bus.if_done), 32'h0);
    check("rst_d_done",  32'(bus.d_done),  32'h0);
    check("rst_addr",    32'(bus.mem_addr), 32'h0);
    rst = 1'b0;

    run_cycles(20, 1'b0);
    run_cycles(3000, 1'b1);
    drain();

    // Misaligned load: no memory access, done+err right after grant.
    bus.d_req  = 1'b1;
    bus.d_wr   = 1'b0;
    bus.d_addr = 16'h0101;
    run_cycles(4, 1'b0);
    drain();

    // Reset during the second ACCESS cycle of a fetch.
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0010;
    run_cycles(2, 1'b0);
    check("pre_rst_mem_en", 32'(bus.mem_en), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("async_mem_en",  32'(bus.mem_en),  32'h0);
    check("async_busy",    32'(bus.busy),    32'h0);
    check("async_if_done", 32'(bus.if_done), 32'h0);
    bus.if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_cycles(8, 1'b0);

    // Fetch of 0xABCD at 0x0010; request dropped and address changed after grant.
    poke_addr = 8'h10;
    poke_data = 16'hABCD;
    poke      = 1'b1;
    @(negedge clk);
    poke = 1'b0;
    ref_mem[16] = 16'hABCD;
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0010;
    run_cycles(2, 1'b0);
    bus.if_req  = 1'b0;
    bus.if_addr = 16'h0020;
    run_cycles(6, 1'b0);
    check("scn6_served", 32'(t.valid && t.rdata == 16'hABCD && cyc > t.done), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
